// File: rtl/alu_6_lanes_if.sv
// Operand/result bundle for the six-lane ALU: packed 192-bit A/B/C plus mode, select and zero flag.
// The driver side takes the master modport; the ALU takes the slave modport.
interface alu_6_lanes_if;
  logic [191:0] A;
  logic [191:0] B;
  logic         op;
  logic [1:0]   sel;
  logic [191:0] C;
  logic         flagZ;

  modport master (
    output A, B, op, sel,
    input  C, flagZ
  );

  modport slave (
    input  A, B, op, sel,
    output C, flagZ
  );
endinterface

// File: rtl/alu_6_lanes.sv
// Six-lane 32-bit unsigned ALU (scalar on lane 0, vector across all lanes); result and zero flag registered, 1-cycle latency.
// No handshake or backpressure: inputs are sampled on every rising clk edge, one operation per cycle.
module alu_6_lanes (
  input  logic          clk,
  input  logic          rst,
  alu_6_lanes_if.slave  bus
);

  localparam int LANES = 6;
  localparam int LW    = 32;

  typedef logic [LW-1:0] lane_t;

  // Truncating divide; a zero divisor saturates the lane to all ones.
  function automatic lane_t lane_div(input lane_t n, input lane_t d);
    lane_t q;
    if (d == '0) q = '1;
    else         q = n / d;
    return q;
  endfunction

  lane_t                b0;
  logic [LANES*LW-1:0]  res;

  assign b0 = bus.B[LW-1:0];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_t a_i;
    lane_t b_i;
    lane_t r_i;

    assign a_i = bus.A[LW*i +: LW];
    assign b_i = bus.B[LW*i +: LW];

    if (i == 0) begin : g_scalar_capable
      always_comb begin
        r_i = '0;
        if (bus.op) begin
          unique case (bus.sel)
            2'b00:   r_i = a_i * b0;
            2'b01:   r_i = lane_div(a_i, b0);
            2'b10:   r_i = a_i + b_i;
            default: r_i = a_i - b_i;
          endcase
        end else begin
          unique case (bus.sel)
            2'b00:   r_i = a_i + b_i;
            2'b01:   r_i = a_i - b_i;
            2'b10:   r_i = a_i * b_i;
            default: r_i = lane_div(a_i, b_i);
          endcase
        end
      end
    end else begin : g_vector_only
      // Upper lanes are forced to zero in scalar mode.
      always_comb begin
        r_i = '0;
        if (bus.op) begin
          unique case (bus.sel)
            2'b00:   r_i = a_i * b0;
            2'b01:   r_i = lane_div(a_i, b0);
            2'b10:   r_i = a_i + b_i;
            default: r_i = a_i - b_i;
          endcase
        end
      end
    end

    assign res[LW*i +: LW] = r_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.C     <= '0;
      bus.flagZ <= 1'b1;
    end else begin
      bus.C     <= res;
      bus.flagZ <= (res == '0);
    end
  end

endmodule

// File: tb/tb_alu_6_lanes.sv
// Self-checking bench for alu_6_lanes: directed cases from the test plan plus randomized
// back-to-back traffic compared against a lane-by-lane arithmetic reference model.
module tb_alu_6_lanes;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_6_lanes_if bus ();

  alu_6_lanes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam longint unsigned M32 = 64'h1_0000_0000;

  function automatic logic [191:0] pack6(input logic [31:0] l5, l4, l3, l2, l1, l0);
    return {l5, l4, l3, l2, l1, l0};
  endfunction

  // Reference: each lane evaluated separately with 64-bit arithmetic reduced mod 2^32.
  function automatic logic [191:0] model_c(input logic [191:0] a, input logic [191:0] b,
                                           input logic op, input logic [1:0] sel);
    logic [191:0]    res;
    longint unsigned ai, bi, b0, r;
    res = '0;
    b0  = longint'(b[31:0]);
    for (int i = 0; i < 6; i++) begin
      ai = longint'(a[32*i +: 32]);
      bi = longint'(b[32*i +: 32]);
      r  = 0;
      if (op == 1'b0) begin
        if (i == 0) begin
          case (sel)
            2'd0: r = ai + bi;
            2'd1: r = ai + M32 - bi;
            2'd2: r = ai * bi;
            default: r = (bi == 0) ? 64'hFFFF_FFFF : ai / bi;
          endcase
        end
      end else begin
        case (sel)
          2'd0: r = ai * b0;
          2'd1: r = (b0 == 0) ? 64'hFFFF_FFFF : ai / b0;
          2'd2: r = ai + bi;
          default: r = ai + M32 - bi;
        endcase
      end
      res[32*i +: 32] = 32'(r % M32);
    end
    return res;
  endfunction

  task automatic apply(input logic [191:0] a, input logic [191:0] b,
                       input logic op, input logic [1:0] sel);
    bus.A   = a;
    bus.B   = b;
    bus.op  = op;
    bus.sel = sel;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    bus.A = rand192(); bus.B = rand192(); bus.op = 1'b1; bus.sel = 2'b10;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.C !== 192'd0 || bus.flagZ !== 1'b1) begin
      errors++;
      $display("FAIL reset: C=%h flagZ=%b, want C=0 flagZ=1", bus.C, bus.flagZ);
    end
    rst = 1'b0;
  endtask

  task automatic test_scalar();
    logic [31:0] want [4] = '{32'd34, 32'd28, 32'd93, 32'd10};
    for (int s = 0; s < 4; s++) begin
      apply(192'd31, 192'd3, 1'b0, 2'(s));
      checks++;
      if (bus.C !== {160'd0, want[s]} || bus.flagZ !== 1'b0) begin
        errors++;
        $display("FAIL scalar sel=%0d: C=%h flagZ=%b, want C=%0d flagZ=0", s, bus.C, bus.flagZ, want[s]);
      end
    end
  endtask

  task automatic test_zero_flag();
    apply(192'd3, 192'd3, 1'b0, 2'b01);
    checks++;
    if (bus.C !== 192'd0 || bus.flagZ !== 1'b1) begin
      errors++;
      $display("FAIL zero_flag: C=%h flagZ=%b, want C=0 flagZ=1", bus.C, bus.flagZ);
    end
    apply(192'd0, 192'd1, 1'b0, 2'b01);
    checks++;
    if (bus.C !== {160'd0, 32'hFFFF_FFFF} || bus.flagZ !== 1'b0) begin
      errors++;
      $display("FAIL sub_wrap: C=%h flagZ=%b, want C=ffffffff flagZ=0", bus.C, bus.flagZ);
    end
  endtask

  task automatic test_vector_scalar();
    logic [191:0] a;
    logic [191:0] b;
    a = pack6(6, 5, 4, 3, 2, 1);
    b = pack6(9, 9, 9, 9, 9, 3);
    apply(a, b, 1'b1, 2'b00);
    checks++;
    if (bus.C !== pack6(18, 15, 12, 9, 6, 3) || bus.flagZ !== 1'b0) begin
      errors++;
      $display("FAIL vec_mul_scalar: C=%h flagZ=%b, want %h", bus.C, bus.flagZ, pack6(18, 15, 12, 9, 6, 3));
    end
    apply(a, b, 1'b1, 2'b01);
    checks++;
    if (bus.C !== pack6(2, 1, 1, 1, 0, 0) || bus.flagZ !== 1'b0) begin
      errors++;
      $display("FAIL vec_div_scalar: C=%h flagZ=%b, want %h", bus.C, bus.flagZ, pack6(2, 1, 1, 1, 0, 0));
    end
  endtask

  task automatic test_vector_vector();
    logic [191:0] v;
    v = pack6(6, 5, 4, 3, 2, 1);
    apply(v, v, 1'b1, 2'b10);
    checks++;
    if (bus.C !== pack6(12, 10, 8, 6, 4, 2) || bus.flagZ !== 1'b0) begin
      errors++;
      $display("FAIL vec_add: C=%h flagZ=%b, want %h", bus.C, bus.flagZ, pack6(12, 10, 8, 6, 4, 2));
    end
    apply(v, v, 1'b1, 2'b11);
    checks++;
    if (bus.C !== 192'd0 || bus.flagZ !== 1'b1) begin
      errors++;
      $display("FAIL vec_sub_zero: C=%h flagZ=%b, want C=0 flagZ=1", bus.C, bus.flagZ);
    end
    apply(pack6(6, 5, 4, 3, 2, 32'hFFFF_FFFF), pack6(6, 5, 4, 3, 2, 1), 1'b1, 2'b10);
    checks++;
    if (bus.C[31:0] !== 32'd0 || bus.C[63:32] !== 32'd4) begin
      errors++;
      $display("FAIL no_cross_carry: lane0=%h lane1=%h, want lane0=0 lane1=4", bus.C[31:0], bus.C[63:32]);
    end
  endtask

  task automatic test_div_zero_reset();
    apply(192'd1234, 192'd0, 1'b0, 2'b11);
    checks++;
    if (bus.C !== {160'd0, 32'hFFFF_FFFF} || bus.flagZ !== 1'b0) begin
      errors++;
      $display("FAIL div_zero: C=%h flagZ=%b, want C=ffffffff flagZ=0", bus.C, bus.flagZ);
    end
    rst = 1'b1;
    apply(192'd31, 192'd3, 1'b0, 2'b00);
    checks++;
    if (bus.C !== 192'd0 || bus.flagZ !== 1'b1) begin
      errors++;
      $display("FAIL reset_priority: C=%h flagZ=%b, want C=0 flagZ=1", bus.C, bus.flagZ);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.C !== 192'd34 || bus.flagZ !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: C=%h flagZ=%b, want C=34 flagZ=0", bus.C, bus.flagZ);
    end
  endtask

  // Random operands changing every cycle, including vector divide-by-zero and small values.
  task automatic test_back_to_back();
    logic [191:0] a;
    logic [191:0] b;
    logic [191:0] exp_c;
    logic         op;
    logic [1:0]   sel;
    for (int n = 0; n < 400; n++) begin
      a   = rand192();
      b   = rand192();
      op  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: b[31:0] = 32'd0;
        1: begin a = a & {6{32'h0000_00FF}}; b = b & {6{32'h0000_000F}}; end
        2: b = a;
        default: ;
      endcase
      exp_c = model_c(a, b, op, sel);
      apply(a, b, op, sel);
      checks++;
      if (bus.C !== exp_c || bus.flagZ !== (exp_c == 192'd0)) begin
        errors++;
        $display("FAIL random[%0d] op=%b sel=%0d: C=%h flagZ=%b, want C=%h flagZ=%b",
                 n, op, sel, bus.C, bus.flagZ, exp_c, (exp_c == 192'd0));
      end
    end
  endtask

  initial begin
    bus.A = '0; bus.B = '0; bus.op = 1'b0; bus.sel = 2'b00;
    test_reset();
    test_scalar();
    test_zero_flag();
    test_vector_scalar();
    test_vector_vector();
    test_div_zero_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
